// File: rtl/control_status_unit_if.sv
// CSR access channel: request fields from the core, registered response from the CSR unit.
// One request per cycle when csr_valid is high; the response follows one cycle later.
interface control_status_unit_if;
    logic        csr_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_index;
    logic [31:0] csr_wdata;
    logic        csr_resp_valid;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    modport master (
        output csr_valid, csr_op, csr_index, csr_wdata,
        input  csr_resp_valid, csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_valid, csr_op, csr_index, csr_wdata,
        output csr_resp_valid, csr_rdata, csr_illegal
    );
endinterface

// File: rtl/control_status_unit.sv
// CSR block: approximation control registers, counter inhibit/overflow status and performance counters.
// Latency: response one cycle after request. Backpressure: none, a request is accepted every valid cycle.
// Counters tick every cycle their event fires unless inhibited; a CSR write to a counter overrides the tick.
module control_status_unit #(
    parameter int          NUM_APPROX  = 3,
    parameter logic [11:0] APPROX_BASE = 12'h800,
    parameter int          NUM_HPM     = 4,
    parameter int          CNT_WIDTH   = 64,
    localparam int         HPM_W       = (NUM_HPM > 0) ? NUM_HPM : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    control_status_unit_if.slave       csr,
    input  logic                       instret_event,
    input  logic [HPM_W-1:0]           hpm_event,
    output logic [NUM_APPROX*32-1:0]   approx_csr_bus,
    output logic                       overflow_irq
);

    // Counter slots: 0 = cycle, 1 = instret, 2+i = hpm i.
    localparam int NCNT = 2 + NUM_HPM;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    // Bit position of a counter slot inside mcountinhibit / ovfstat.
    function automatic int ctr_bit(input int slot);
        return (slot == 0) ? 0 : slot + 1;
    endfunction

    function automatic logic [31:0] ctr_mask();
        logic [31:0] m;
        m = '0;
        for (int s = 0; s < NCNT; s++) begin
            m[ctr_bit(s)] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [31:0] CTR_MASK = ctr_mask();

    logic [31:0]          approx_q [NUM_APPROX];
    logic [31:0]          inhibit_q;
    logic [31:0]          ovf_q;
    logic [CNT_WIDTH-1:0] cnt_q [NCNT];

    logic [CNT_WIDTH-1:0] cnt_d [NCNT];
    logic [31:0]          ovf_d;
    logic [31:0]          ovf_set;
    logic [NCNT-1:0]      cnt_ev;

    logic [11:0] approx_off;
    logic [6:0]  cnt_num;
    logic [3:0]  cnt_slot;
    logic        hit_approx;
    logic        hit_inh;
    logic        hit_ovf;
    logic        hit_cnt;
    logic        cnt_hi;
    logic        mapped;
    logic        wants_write;
    logic        illegal_d;
    logic        wr_en;
    logic [31:0] old_val;
    logic [31:0] new_val;

    always_comb begin
        cnt_ev    = '0;
        cnt_ev[0] = 1'b1;
        cnt_ev[1] = instret_event;
        for (int i = 0; i < NUM_HPM; i++) begin
            cnt_ev[2+i] = hpm_event[i];
        end
    end

    // Address decode; the approximation window takes priority if a base overlaps another CSR.
    always_comb begin
        approx_off = csr.csr_index - APPROX_BASE;
        hit_approx = int'(approx_off) < NUM_APPROX;
        hit_inh    = !hit_approx && (csr.csr_index == 12'h320);
        hit_ovf    = !hit_approx && (csr.csr_index == 12'h7C0);
        cnt_num    = csr.csr_index[6:0];
        cnt_hi     = csr.csr_index[7];
        cnt_slot   = '0;
        hit_cnt    = 1'b0;
        if (!hit_approx && (csr.csr_index[11:8] == 4'hB || csr.csr_index[11:8] == 4'hC)) begin
            if (cnt_num == 7'd0) begin
                hit_cnt  = 1'b1;
                cnt_slot = 4'd0;
            end else if (cnt_num == 7'd2) begin
                hit_cnt  = 1'b1;
                cnt_slot = 4'd1;
            end else if (cnt_num >= 7'd3 && int'(cnt_num) < 3 + NUM_HPM) begin
                hit_cnt  = 1'b1;
                cnt_slot = 4'(cnt_num - 7'd1);
            end
        end
        mapped = hit_approx || hit_inh || hit_ovf || hit_cnt;
    end

    always_comb begin
        old_val = '0;
        if (hit_approx) begin
            for (int k = 0; k < NUM_APPROX; k++) begin
                if (approx_off == 12'(k)) old_val = approx_q[k];
            end
        end else if (hit_inh) begin
            old_val = inhibit_q;
        end else if (hit_ovf) begin
            old_val = ovf_q;
        end else if (hit_cnt) begin
            for (int s = 0; s < NCNT; s++) begin
                if (cnt_slot == 4'(s)) begin
                    old_val = cnt_hi ? 32'(cnt_q[s][CNT_WIDTH-1:32]) : cnt_q[s][31:0];
                end
            end
        end
    end

    // Set/clear with an empty mask is a pure read, so it never trips the read-only check.
    always_comb begin
        wants_write = csr.csr_valid &&
                      (csr.csr_op == OP_RW || (csr.csr_op[1] && csr.csr_wdata != 32'h0));
        illegal_d   = csr.csr_valid &&
                      (!mapped || (wants_write && csr.csr_index[11:10] == 2'b11));
        wr_en       = wants_write && !illegal_d;
        case (csr.csr_op)
            OP_RW:   new_val = csr.csr_wdata;
            OP_RS:   new_val = old_val | csr.csr_wdata;
            OP_RC:   new_val = old_val & ~csr.csr_wdata;
            default: new_val = old_val;
        endcase
    end

    always_comb begin
        ovf_set = '0;
        for (int s = 0; s < NCNT; s++) begin
            cnt_d[s] = cnt_q[s];
            if (wr_en && hit_cnt && cnt_slot == 4'(s)) begin
                if (cnt_hi) begin
                    cnt_d[s] = {new_val[CNT_WIDTH-33:0], cnt_q[s][31:0]};
                end else begin
                    cnt_d[s] = {cnt_q[s][CNT_WIDTH-1:32], new_val};
                end
            end else if (cnt_ev[s] && !inhibit_q[ctr_bit(s)]) begin
                cnt_d[s] = cnt_q[s] + CNT_ONE;
                if (&cnt_q[s]) ovf_set[ctr_bit(s)] = 1'b1;
            end
        end
        // A hardware overflow in the same cycle as a software clear stays visible.
        ovf_d = (((wr_en && hit_ovf) ? new_val : ovf_q) | ovf_set) & CTR_MASK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_APPROX; k++) approx_q[k] <= '0;
            for (int s = 0; s < NCNT; s++) cnt_q[s] <= '0;
            inhibit_q          <= '0;
            ovf_q              <= '0;
            csr.csr_resp_valid <= 1'b0;
            csr.csr_rdata      <= '0;
            csr.csr_illegal    <= 1'b0;
        end else begin
            csr.csr_resp_valid <= csr.csr_valid;
            csr.csr_illegal    <= illegal_d;
            if (csr.csr_valid) csr.csr_rdata <= old_val;
            for (int k = 0; k < NUM_APPROX; k++) begin
                if (wr_en && hit_approx && approx_off == 12'(k)) approx_q[k] <= new_val;
            end
            if (wr_en && hit_inh) inhibit_q <= new_val & CTR_MASK;
            ovf_q <= ovf_d;
            for (int s = 0; s < NCNT; s++) cnt_q[s] <= cnt_d[s];
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_APPROX; k++) begin
            approx_csr_bus[32*k +: 32] = approx_q[k];
        end
    end

    assign overflow_irq = |ovf_q;

endmodule
